// File: rtl/packet_decoder_pkg.sv
// Shared constants for the camera packet decoder.
// Holds the packet geometry, the preamble value, the metadata byte positions,
// the FSM state encoding and the 2-of-3 byte vote helper.
package packet_decoder_pkg;

  localparam int PACKET_LEN  = 64;
  localparam int MAX_PAYLOAD = PACKET_LEN - 8;
  localparam int IDLE_BITS   = 24;

  localparam logic [7:0]  PREAMBLE      = 8'h92;
  localparam logic [23:0] SYNC_WORD     = {PREAMBLE, PREAMBLE, PREAMBLE};
  localparam logic [7:0]  MAX_PAYLOAD_B = 8'(MAX_PAYLOAD);
  localparam logic [4:0]  IDLE_LOAD     = 5'(IDLE_BITS);

  // Byte positions inside a packet slot (k = 0 is the preamble).
  localparam logic [5:0] K_LAST_PAYLOAD = 6'(MAX_PAYLOAD);
  localparam logic [5:0] K_PAD          = 6'd57;
  localparam logic [5:0] K_SEQ_HI       = 6'd58;
  localparam logic [5:0] K_SEQ_LO       = 6'd60;
  localparam logic [5:0] K_LEN          = 6'd61;

  localparam logic [1:0] ST_HUNT = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_SKIP = 2'd2;

  // Bitwise majority across the three received copies held in the shifter.
  function automatic logic [7:0] vote_byte(input logic [23:0] sr);
    logic [7:0] v;
    for (int b = 0; b < 8; b++) begin
      v[b] = (sr[16+b] & sr[8+b]) | (sr[16+b] & sr[b]) | (sr[8+b] & sr[b]);
    end
    return v;
  endfunction

endpackage

// File: rtl/packet_decoder_payload_buffer.sv
// Payload staging buffer: MAX_PAYLOAD x 8 register file.
// Ports: clock; wr_en/wr_addr/wr_data synchronous write from the receive
// side; rd_addr/rd_data asynchronous read for the drain side.
// Contents are not reset; a packet always rewrites what it later drains.
module packet_decoder_payload_buffer
  import packet_decoder_pkg::*;
(
  input  logic       clock,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem_q [MAX_PAYLOAD];

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = (rd_addr < K_LAST_PAYLOAD) ? mem_q[rd_addr] : 8'h00;

endmodule

// File: rtl/packet_decoder.sv
// Camera packet decoder (receive side).
// Aligns on the triple-sent preamble, majority-votes each tripled byte,
// buffers payload until metadata arrives, then drains it to a FIFO.
// Ports: clock, reset (async, active high), input_data (serial, MSB first);
// output_data/fifo_we/fifo_full FIFO write side; pkt_done/pkt_len/pkt_seq/
// pkt_err packet status; ovf_err drain-abort pulse.
// Optional: define PKT_DEC_SEQ_CHECK_EN to add the seq_gap output.
//
// state | meaning
// HUNT  | waiting for 0x929292 in the shifter
// RECV  | collecting voted bytes k = 1..61
// SKIP  | ignoring tail until IDLE_BITS consecutive zeros
module packet_decoder
  import packet_decoder_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        input_data,
  output logic [7:0]  output_data,
  output logic        fifo_we,
  input  logic        fifo_full,
  output logic        pkt_done,
  output logic [7:0]  pkt_len,
  output logic [23:0] pkt_seq,
  output logic        pkt_err,
  output logic        ovf_err
`ifdef PKT_DEC_SEQ_CHECK_EN
  ,
  output logic        seq_gap
`endif
);

  logic [1:0]  state_q, state_d;
  logic [23:0] sr_q, sr_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [5:0]  byte_idx_q, byte_idx_d;
  logic [4:0]  idle_left_q, idle_left_d;
  logic        pad_ok_q, pad_ok_d;
  logic [23:0] seq_acc_q, seq_acc_d;
  logic        drain_act_q, drain_act_d;
  logic [5:0]  drain_len_q, drain_len_d;
  logic [5:0]  rd_ptr_q, rd_ptr_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        fifo_we_q, fifo_we_d;
  logic        pkt_done_q, pkt_done_d;
  logic [7:0]  pkt_len_q, pkt_len_d;
  logic [23:0] pkt_seq_q, pkt_seq_d;
  logic        pkt_err_q, pkt_err_d;
  logic        ovf_q, ovf_d;

  logic [7:0]  voted;
  logic        byte_done;
  logic        commit;
  logic        commit_err;
  logic        buf_we;
  logic [5:0]  buf_waddr;
  logic [7:0]  buf_rdata;

`ifdef PKT_DEC_SEQ_CHECK_EN
  logic [23:0] prev_seq_q, prev_seq_d;
  logic        have_prev_q, have_prev_d;
  logic        seq_gap_q, seq_gap_d;
`endif

  packet_decoder_payload_buffer u_buf (
    .clock   (clock),
    .wr_en   (buf_we),
    .wr_addr (buf_waddr),
    .wr_data (voted),
    .rd_addr (rd_ptr_q),
    .rd_data (buf_rdata)
  );

  always_comb begin
    sr_d        = {sr_q[22:0], input_data};
    voted       = vote_byte(sr_d);
    byte_done   = (state_q == ST_RECV) && (bit_cnt_q == 5'd23);
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_idx_d  = byte_idx_q;
    idle_left_d = idle_left_q;
    pad_ok_d    = pad_ok_q;
    seq_acc_d   = seq_acc_q;
    drain_act_d = drain_act_q;
    drain_len_d = drain_len_q;
    rd_ptr_d    = rd_ptr_q;
    out_data_d  = out_data_q;
    fifo_we_d   = 1'b0;
    pkt_done_d  = 1'b0;
    pkt_len_d   = pkt_len_q;
    pkt_seq_d   = pkt_seq_q;
    pkt_err_d   = pkt_err_q;
    ovf_d       = 1'b0;
    buf_we      = 1'b0;
    buf_waddr   = byte_idx_q - 6'd1;
    commit      = 1'b0;
    commit_err  = (voted > MAX_PAYLOAD_B) || !pad_ok_q;
`ifdef PKT_DEC_SEQ_CHECK_EN
    prev_seq_d  = prev_seq_q;
    have_prev_d = have_prev_q;
    seq_gap_d   = 1'b0;
`endif

    case (state_q)
      ST_HUNT: begin
        if (sr_d == SYNC_WORD) begin
          state_d    = ST_RECV;
          byte_idx_d = 6'd1;
          bit_cnt_d  = 5'd0;
          pad_ok_d   = 1'b0;
        end
      end
      ST_RECV: begin
        if (byte_done) begin
          bit_cnt_d  = 5'd0;
          byte_idx_d = byte_idx_q + 6'd1;
          if (byte_idx_q <= K_LAST_PAYLOAD) buf_we = 1'b1;
          if (byte_idx_q == K_PAD) pad_ok_d = (voted == PREAMBLE);
          if (byte_idx_q >= K_SEQ_HI && byte_idx_q <= K_SEQ_LO)
            seq_acc_d = {seq_acc_q[15:0], voted};
          if (byte_idx_q == K_LEN) begin
            state_d     = ST_SKIP;
            idle_left_d = IDLE_LOAD;
            commit      = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      ST_SKIP: begin
        // Tail pads contain ones, so only a true idle gap re-arms the hunt.
        if (input_data) begin
          idle_left_d = IDLE_LOAD;
        end else if (idle_left_q == 5'd1) begin
          idle_left_d = 5'd0;
          state_d     = ST_HUNT;
        end else begin
          idle_left_d = idle_left_q - 5'd1;
        end
      end
      default: state_d = ST_HUNT;
    endcase

    // fifo_full is sampled here and acted on through the fifo_we flop.
    if (drain_act_q && !fifo_full) begin
      fifo_we_d  = 1'b1;
      out_data_d = buf_rdata;
      rd_ptr_d   = rd_ptr_q + 6'd1;
      if ((rd_ptr_q + 6'd1) == drain_len_q) drain_act_d = 1'b0;
    end

    // A new packet's first payload byte overwrites address 0: abandon the old drain.
    if (byte_done && byte_idx_q == 6'd1 && drain_act_q) begin
      drain_act_d = 1'b0;
      fifo_we_d   = 1'b0;
      out_data_d  = out_data_q;
      rd_ptr_d    = rd_ptr_q;
      ovf_d       = 1'b1;
    end

    if (commit) begin
      pkt_done_d = 1'b1;
      pkt_len_d  = voted;
      pkt_seq_d  = seq_acc_q;
      pkt_err_d  = commit_err;
      if (!commit_err && voted != 8'd0) begin
        drain_act_d = 1'b1;
        drain_len_d = voted[5:0];
        rd_ptr_d    = 6'd0;
      end
`ifdef PKT_DEC_SEQ_CHECK_EN
      if (!commit_err) begin
        seq_gap_d   = have_prev_q && (seq_acc_q != (prev_seq_q + {16'd0, voted}));
        prev_seq_d  = seq_acc_q;
        have_prev_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HUNT;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      byte_idx_q  <= '0;
      idle_left_q <= '0;
      pad_ok_q    <= 1'b0;
      seq_acc_q   <= '0;
      drain_act_q <= 1'b0;
      drain_len_q <= '0;
      rd_ptr_q    <= '0;
      out_data_q  <= '0;
      fifo_we_q   <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_len_q   <= '0;
      pkt_seq_q   <= '0;
      pkt_err_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_idx_q  <= byte_idx_d;
      idle_left_q <= idle_left_d;
      pad_ok_q    <= pad_ok_d;
      seq_acc_q   <= seq_acc_d;
      drain_act_q <= drain_act_d;
      drain_len_q <= drain_len_d;
      rd_ptr_q    <= rd_ptr_d;
      out_data_q  <= out_data_d;
      fifo_we_q   <= fifo_we_d;
      pkt_done_q  <= pkt_done_d;
      pkt_len_q   <= pkt_len_d;
      pkt_seq_q   <= pkt_seq_d;
      pkt_err_q   <= pkt_err_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef PKT_DEC_SEQ_CHECK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_seq_q  <= '0;
      have_prev_q <= 1'b0;
      seq_gap_q   <= 1'b0;
    end else begin
      prev_seq_q  <= prev_seq_d;
      have_prev_q <= have_prev_d;
      seq_gap_q   <= seq_gap_d;
    end
  end
  assign seq_gap = seq_gap_q;
`endif

  assign output_data = out_data_q;
  assign fifo_we     = fifo_we_q;
  assign pkt_done    = pkt_done_q;
  assign pkt_len     = pkt_len_q;
  assign pkt_seq     = pkt_seq_q;
  assign pkt_err     = pkt_err_q;
  assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_packet_decoder.sv
module tb_packet_decoder;
  import packet_decoder_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        input_data;
  logic        fifo_full;
  logic [7:0]  output_data;
  logic        fifo_we;
  logic        pkt_done;
  logic [7:0]  pkt_len;
  logic [23:0] pkt_seq;
  logic        pkt_err;
  logic        ovf_err;
`ifdef PKT_DEC_SEQ_CHECK_EN
  logic        seq_gap;
`endif

  packet_decoder dut (
    .clock       (clock),
    .reset       (reset),
    .input_data  (input_data),
    .output_data (output_data),
    .fifo_we     (fifo_we),
    .fifo_full   (fifo_full),
    .pkt_done    (pkt_done),
    .pkt_len     (pkt_len),
    .pkt_seq     (pkt_seq),
    .pkt_err     (pkt_err),
    .ovf_err     (ovf_err)
`ifdef PKT_DEC_SEQ_CHECK_EN
    ,
    .seq_gap     (seq_gap)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]  len;
    logic [23:0] seq;
    logic        err;
  } meta_t;

  logic [7:0] exp_data [$];
  meta_t      exp_meta [$];
  logic [7:0] pay [0:55];

  int   n_vec = 0;
  int   n_miss = 0;
  int   n_writes = 0;
  int   n_done = 0;
  int   n_ovf = 0;
  logic full_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT presents output.
  always @(posedge clock) full_seen <= fifo_full;

  always @(negedge clock) begin
    if (!reset) begin
      if (fifo_we) begin
        n_writes++;
        check("write_while_full", 32'(full_seen), 32'd0);
        if (exp_data.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_write: got %0h expected no write", output_data);
        end else begin
          logic [7:0] e;
          e = exp_data.pop_front();
          check("wdata", 32'(output_data), 32'(e));
        end
      end
      if (pkt_done) begin
        n_done++;
        if (exp_meta.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_done: got len %0h seq %0h expected no pkt_done", pkt_len, pkt_seq);
        end else begin
          meta_t m;
          m = exp_meta.pop_front();
          check("pkt_len", 32'(pkt_len), 32'(m.len));
          check("pkt_seq", 32'(pkt_seq), 32'(m.seq));
          check("pkt_err", 32'(pkt_err), 32'(m.err));
        end
      end
      if (ovf_err) n_ovf++;
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clock);
    input_data = b;
  endtask

  task automatic send_copy(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  // corrupt flips one bit (varying with k) in the middle copy only.
  task automatic send_byte(input logic [7:0] v, input bit corrupt, input int k);
    logic [7:0] c;
    c = corrupt ? (v ^ (8'h01 << (k % 8))) : v;
    send_copy(v);
    send_copy(c);
    send_copy(v);
  endtask

  task automatic send_packet(input int n, input logic [7:0] len_f, input logic [23:0] seq,
                             input logic [7:0] pad57, input bit corrupt, input int tail,
                             input int idle);
    send_byte(PREAMBLE, 1'b0, 0);
    for (int k = 1; k <= 57; k++) begin
      logic [7:0] v;
      if (k <= n) v = pay[k-1];
      else if (k == 57) v = pad57;
      else v = PREAMBLE;
      send_byte(v, corrupt, k);
    end
    send_byte(seq[23:16], corrupt, 58);
    send_byte(seq[15:8], corrupt, 59);
    send_byte(seq[7:0], corrupt, 60);
    send_byte(len_f, corrupt, 61);
    repeat (tail) send_byte(PREAMBLE, 1'b0, 0);
    repeat (idle) send_bit(1'b0);
  endtask

  task automatic expect_pkt(input int n, input logic [7:0] len, input logic [23:0] seq,
                            input logic err, input bit data);
    meta_t m;
    m.len = len;
    m.seq = seq;
    m.err = err;
    exp_meta.push_back(m);
    if (data) for (int i = 0; i < n; i++) exp_data.push_back(pay[i]);
  endtask

  task automatic wait_empty(input string name, input int budget);
    int c;
    c = 0;
    while ((exp_data.size() != 0 || exp_meta.size() != 0) && c < budget) begin
      @(negedge clock);
      c++;
    end
    check(name, 32'(exp_data.size() + exp_meta.size()), 32'd0);
  endtask

  task automatic set_abc();
    pay[0] = 8'hA5;
    pay[1] = 8'h3C;
    pay[2] = 8'hFF;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, o0;
    reset      = 1'b1;
    input_data = 1'b0;
    fifo_full  = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_output_data", 32'(output_data), 32'd0);
    check("rst_fifo_we", 32'(fifo_we), 32'd0);
    check("rst_pkt_done", 32'(pkt_done), 32'd0);
    check("rst_pkt_len", 32'(pkt_len), 32'd0);
    check("rst_pkt_seq", 32'(pkt_seq), 32'd0);
    check("rst_pkt_err", 32'(pkt_err), 32'd0);
    check("rst_ovf_err", 32'(ovf_err), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Clean packet.
    set_abc();
    d0 = n_done;
    expect_pkt(3, 8'd3, 24'h000003, 1'b0, 1'b1);
    send_packet(3, 8'd3, 24'h000003, PREAMBLE, 1'b0, 3, 30);
    wait_empty("s1_drain", 200);
    check("s1_done_count", 32'(n_done - d0), 32'd1);
    check("s1_len_hold", 32'(pkt_len), 32'd3);

    // Middle copy corrupted everywhere after the preamble.
    expect_pkt(3, 8'd3, 24'h000003, 1'b0, 1'b1);
    send_packet(3, 8'd3, 24'h000003, PREAMBLE, 1'b1, 3, 30);
    wait_empty("s2_drain", 200);

    // FIFO full across commit and for 10 cycles after pkt_done.
    expect_pkt(3, 8'd3, 24'h000003, 1'b0, 1'b1);
    w0 = n_writes;
    fifo_full = 1'b1;
    fork
      send_packet(3, 8'd3, 24'h000003, PREAMBLE, 1'b0, 3, 30);
      begin : hold_branch
        int c;
        c = 0;
        while (!pkt_done && c < 4000) begin
          @(negedge clock);
          c++;
        end
        check("s3_done_seen", 32'(pkt_done), 32'd1);
        repeat (10) @(negedge clock);
        check("s3_writes_during_hold", 32'(n_writes - w0), 32'd0);
        fifo_full = 1'b0;
      end
    join
    wait_empty("s3_drain", 200);
    check("s3_write_count", 32'(n_writes - w0), 32'd3);

    // Oversize length, then bad pad byte 57.
    expect_pkt(3, 8'h40, 24'h000010, 1'b1, 1'b0);
    send_packet(3, 8'h40, 24'h000010, PREAMBLE, 1'b0, 3, 30);
    wait_empty("s4a_meta", 200);
    check("s4a_err_hold", 32'(pkt_err), 32'd1);
    expect_pkt(3, 8'd3, 24'h000011, 1'b1, 1'b0);
    send_packet(3, 8'd3, 24'h000011, 8'h00, 1'b0, 3, 30);
    wait_empty("s4b_meta", 200);
    check("s4b_err_hold", 32'(pkt_err), 32'd1);

    // Full 56-byte payload with a long tail.
    for (int i = 0; i < 56; i++) pay[i] = 8'(i);
    d0 = n_done;
    w0 = n_writes;
    expect_pkt(56, 8'd56, 24'h000100, 1'b0, 1'b1);
    send_packet(56, 8'd56, 24'h000100, PREAMBLE, 1'b0, 9, 30);
    wait_empty("s5_drain", 200);
    check("s5_done_count", 32'(n_done - d0), 32'd1);
    check("s5_write_count", 32'(n_writes - w0), 32'd56);

    // Back-to-back without idle gap: second packet must not sync.
    set_abc();
    d0 = n_done;
    expect_pkt(3, 8'd3, 24'h000200, 1'b0, 1'b1);
    send_packet(3, 8'd3, 24'h000200, PREAMBLE, 1'b0, 3, 0);
    send_packet(3, 8'd3, 24'h123456, PREAMBLE, 1'b0, 3, 30);
    wait_empty("s5b_drain", 200);
    check("s5b_done_count", 32'(n_done - d0), 32'd1);

    // Reset in the middle of payload byte 20.
    for (int i = 0; i < 56; i++) pay[i] = 8'h40 + 8'(i);
    send_byte(PREAMBLE, 1'b0, 0);
    for (int k = 1; k <= 19; k++) send_byte(pay[k-1], 1'b0, k);
    for (int i = 0; i < 10; i++) send_bit(pay[19][7 - (i % 8)]);
    @(negedge clock);
    reset = 1'b1;
    input_data = 1'b0;
    #1;
    check("s6_rst_pkt_len", 32'(pkt_len), 32'd0);
    check("s6_rst_pkt_seq", 32'(pkt_seq), 32'd0);
    check("s6_rst_fifo_we", 32'(fifo_we), 32'd0);
    check("s6_rst_pkt_done", 32'(pkt_done), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    pay[0] = 8'hDE;
    pay[1] = 8'hAD;
    pay[2] = 8'hBE;
    pay[3] = 8'hEF;
    expect_pkt(4, 8'd4, 24'h000042, 1'b0, 1'b1);
    send_packet(4, 8'd4, 24'h000042, PREAMBLE, 1'b0, 3, 30);
    wait_empty("s6_drain", 200);

    // Stalled drain overtaken by the next packet.
    check("no_ovf_before_s7", 32'(n_ovf), 32'd0);
    o0 = n_ovf;
    fifo_full = 1'b1;
    set_abc();
    expect_pkt(3, 8'd3, 24'h000300, 1'b0, 1'b0);
    send_packet(3, 8'd3, 24'h000300, PREAMBLE, 1'b0, 3, 30);
    pay[0] = 8'h11;
    pay[1] = 8'h22;
    expect_pkt(2, 8'd2, 24'h000305, 1'b0, 1'b1);
    send_packet(2, 8'd2, 24'h000305, PREAMBLE, 1'b0, 3, 30);
    fifo_full = 1'b0;
    wait_empty("s7_drain", 200);
    check("s7_ovf_count", 32'(n_ovf - o0), 32'd1);

    repeat (5) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/packet_decoder.md
Name: packet_decoder

Overview:
Receive-side counterpart of the camera packet encoder. It takes the serial line one bit per clock and aligns on the triple-sent 0x92 preamble. Each byte arrives as three back-to-back copies, and the decoder majority-votes them into one byte. Payload is buffered until the fixed-position metadata (seq number, payload size) arrives, then drained into a downstream FIFO.

Parameters:
PACKET_LEN, 64, total bytes per packet slot; max payload is PACKET_LEN-8 (56).
PREAMBLE, 8'h92, header, pad and tail byte value.
IDLE_BITS, 24, consecutive zero line bits needed to re-arm the hunt.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
input_data  in  1  serial line, one bit sampled every clock, MSB first, each byte sent 3x
output_data  out  8  payload byte to downstream FIFO
fifo_we  out  1  write strobe for output_data
fifo_full  in  1  downstream FIFO full; no write while high
pkt_done  out  1  one-cycle pulse when metadata of a packet is decoded
pkt_len  out  8  decoded payload size; held until the next pkt_done
pkt_seq  out  24  decoded seq number; held until the next pkt_done
pkt_err  out  1  held with pkt_done: length > 56, or byte 57 != PREAMBLE
ovf_err  out  1  one-cycle pulse: drain aborted by a new packet's payload

Behaviour:
- Reset: all outputs 0, FSM=HUNT, shift register 0, counters 0, buffer contents don't-care. A reset mid-packet or mid-drain discards everything.
- Shift register sr[23:0] shifts input_data into the LSB every clock in every state.
- Byte vote: after 24 bits, for each b in 0..7, byte[b] = maj(sr[16+b], sr[8+b], sr[b]).
- Packet layout (byte index k): k=0 preamble; k=1..L payload; then PREAMBLE pads up to k=57; k=58..60 seq[23:16], seq[15:8], seq[7:0]; k=61 L; k=62+ PREAMBLE tail, ignored.
- HUNT: when sr (after update) == 24'h929292, go to RECV with byte index k=1 and bit count 0. The next clock carries the first bit of byte 1. Matching is exact, with no voting.
- RECV: bit count runs 0..23. On count 23 the voted byte is complete, then:
  - k 1..56: written to buffer address k-1.
  - k 57: compared to PREAMBLE.
  - k 58..61: captured as metadata.
  - After k=61 go to SKIP.
- Commit: the cycle after k=61 completes:
  - pkt_done=1; pkt_len and pkt_seq load.
  - pkt_err=(L>56) || (byte57 != PREAMBLE).
  - If !pkt_err and L>0, the drain starts that same cycle.
- SKIP: count consecutive zero input bits; any 1 resets the count. On reaching IDLE_BITS go to HUNT. The tail pads (0x929292 patterns) therefore never re-trigger a sync. The sender must idle at least 24 clocks between packets.
- Drain: read pointer 0..L-1. Each cycle with fifo_full=0: fifo_we=1, output_data=buf[ptr], ptr++. With fifo_full=1: fifo_we=0 and the pointer holds. No combinational path from fifo_full to fifo_we beyond a single registered stage; the output is registered and the pointer advances only on an accepted write. Drain ends after L writes.
- Overflow: if a new packet's byte 1 completes while the drain is unfinished, the drain aborts (no further fifo_we) and ovf_err pulses that cycle. The new packet is then received normally.
- pkt_len, pkt_seq and pkt_err are not cleared by HUNT; only reset or the next commit changes them.

Optional Feature:
PKT_DEC_SEQ_CHECK_EN:
- Defined: adds output seq_gap (1 bit), a pulse with pkt_done when the packet is not the first since reset and pkt_seq != prev_seq + L (24-bit wrap). Packets with pkt_err do not update prev_seq and never raise seq_gap.
- Undefined: port absent, no comparison logic.

Decomposition:
- Shared package: PACKET_LEN, PREAMBLE, derived MAX_PAYLOAD=PACKET_LEN-8, metadata byte indices (57 pad, 58..60 seq, 61 len), FSM state encoding {HUNT, RECV, SKIP}.
- Sub-module: payload_buffer, a 56x8 register file with one synchronous write port (receive side) and one read port (drain side).

Test Plan:
1. Clean packet, payload A5 3C FF, seq 0x000003, L=3, pads per layout -> pkt_done once; pkt_len=3; pkt_seq=000003; pkt_err=0; fifo_we x3 writing A5, 3C, FF in order.
2. Same packet with one copy of each byte corrupted (a single bit flipped in copy 2) -> identical outputs to scenario 1.
3. Scenario 1 with fifo_full held high for 10 cycles after pkt_done -> no writes during the hold, then A5, 3C, FF with nothing lost or duplicated.
4. Length byte 0x40 (64) -> pkt_err=1, pkt_len=0x40, zero fifo_we. Separately, byte57 = 0x00 -> pkt_err=1.
5. Full 56-byte packet 00..37, tail pads for 200 clocks, then 30 zero clocks -> exactly one pkt_done and 56 writes; HUNT re-armed. Without the idle gap, no second sync occurs.
6. Reset asserted at payload byte 20 -> all outputs 0 immediately. The following clean packet decodes correctly.
